rcvr_frame_ctrl: RTL and testbench

Master-side sequencer for the 16-bit serial word link. Generates the serial bit clock and frame sync and samples serial data MSB-first. Assembles WORDS-word frames and hands each word to a downstream consumer over a valid/ready handshake. Sits between the serial pins and the capture/processing logic, and owns link timing, framing, inter-frame gap and overrun reporting.

---
 rtl/rcvr_frame_ctrl_if.sv | 11 +
 rtl/rcvr_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rcvr_frame_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rcvr_frame_ctrl_if.sv
// Downstream word handshake between the frame receiver and its consumer.
// Signal names are from the producer's point of view.
interface rcvr_frame_ctrl_if;
    logic [15:0] o_data;
    logic        o_vld;
    logic        o_sof;
    logic        i_rdy;

    modport master (output o_data, output o_vld, output o_sof, input i_rdy);
    modport slave  (input o_data, input o_vld, input o_sof, output i_rdy);
endinterface

// File: rtl/rcvr_frame_ctrl.sv
// Master-side serial word receiver: drives sclk/fs, shifts i_sd in MSB-first and
// presents each 16-bit word downstream over valid/ready with sticky overrun.
module rcvr_frame_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int WORDS   = 8,
    parameter int GAP     = 4
) (
    input  logic                 i_clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_clr_ovr,
    output logic                 o_sclk,
    output logic                 o_fs,
    input  logic                 i_sd,
    rcvr_frame_ctrl_if.master    dn,
    output logic                 o_busy,
    output logic                 o_ovr,
    output logic [15:0]          o_frame_cnt
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int GAP_W  = $clog2(GAP + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t              state_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [3:0]          bit_reg;
    logic [WORD_W-1:0]   word_reg;
    logic [GAP_W-1:0]    gap_reg;
    logic                sclk_reg;
    logic                fs_reg;
    logic [15:0]         shift_reg;
    logic [15:0]         shift_next;
    logic                done_reg;
    logic                done_sof_reg;
    logic [15:0]         frame_cnt_reg;

    logic [15:0]         data_reg;
    logic                vld_reg;
    logic                sof_reg;
    logic                ovr_reg;

    logic                div_tc;
    logic                rise_ev;
    logic                fall_ev;

    assign div_tc  = (div_reg == DIV_LAST);
    assign rise_ev = div_tc & ~sclk_reg;
    assign fall_ev = div_tc & sclk_reg;

    assign shift_next[0] = i_sd;
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi-1];
        end
    endgenerate

    // Link sequencer: bit clock, frame sync, bit/word framing and inter-frame gap.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            div_reg       <= '0;
            bit_reg       <= '0;
            word_reg      <= '0;
            gap_reg       <= '0;
            sclk_reg      <= 1'b1;
            fs_reg        <= 1'b0;
            shift_reg     <= '0;
            done_reg      <= 1'b0;
            done_sof_reg  <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    sclk_reg <= 1'b1;
                    div_reg  <= '0;
                    if (i_en) begin
                        state_reg <= ST_SHIFT;
                        sclk_reg  <= 1'b0;
                        fs_reg    <= 1'b1;
                        bit_reg   <= '0;
                        word_reg  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (div_tc) begin
                        div_reg  <= '0;
                        sclk_reg <= ~sclk_reg;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                    if (fall_ev) begin
                        fs_reg <= 1'b0;
                    end
                    if (rise_ev) begin
                        shift_reg <= shift_next;
                        if (bit_reg == 4'd15) begin
                            bit_reg      <= '0;
                            done_reg     <= 1'b1;
                            done_sof_reg <= (word_reg == '0);
                            if (word_reg == WORD_LAST) begin
                                word_reg      <= '0;
                                gap_reg       <= '0;
                                state_reg     <= ST_GAP;
                                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                            end else begin
                                word_reg <= word_reg + 1'b1;
                            end
                        end else begin
                            bit_reg <= bit_reg + 4'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (div_tc) begin
                        div_reg  <= '0;
                        sclk_reg <= ~sclk_reg;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                    // The first fall closes the last data bit, so the gap ends on fall GAP+1.
                    if (fall_ev) begin
                        if (gap_reg == GAP_LAST) begin
                            if (i_en) begin
                                state_reg <= ST_SHIFT;
                                fs_reg    <= 1'b1;
                                bit_reg   <= '0;
                                word_reg  <= '0;
                            end else begin
                                state_reg <= ST_IDLE;
                                sclk_reg  <= 1'b1;
                            end
                        end else begin
                            gap_reg <= gap_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    sclk_reg  <= 1'b1;
                    fs_reg    <= 1'b0;
                end
            endcase
        end
    end

    // Output word register; a completed word only loads when the slot is free or being accepted.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            vld_reg  <= 1'b0;
            sof_reg  <= 1'b0;
            ovr_reg  <= 1'b0;
        end else begin
            if (done_reg && (!vld_reg || dn.i_rdy)) begin
                data_reg <= shift_reg;
                vld_reg  <= 1'b1;
                sof_reg  <= done_sof_reg;
            end else if (vld_reg && dn.i_rdy) begin
                vld_reg <= 1'b0;
            end
            if (done_reg && vld_reg && !dn.i_rdy) begin
                ovr_reg <= 1'b1;
            end else if (i_clr_ovr) begin
                ovr_reg <= 1'b0;
            end
        end
    end

    assign o_sclk      = sclk_reg;
    assign o_fs        = fs_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_ovr       = ovr_reg;
    assign o_frame_cnt = frame_cnt_reg;
    assign dn.o_data   = data_reg;
    assign dn.o_vld    = vld_reg;
    assign dn.o_sof    = sof_reg;
endmodule

// File: tb/tb_rcvr_frame_ctrl.sv
// Bench for rcvr_frame_ctrl: far-end serial driver plus a timing-formula reference model
// of frame start, word delivery, handshake and overrun, checked every cycle.
module tb_rcvr_frame_ctrl;
    localparam int CD          = 2;
    localparam int NW          = 2;
    localparam int NG          = 1;
    localparam int NF          = 32;
    localparam int PERIOD      = 2 * CD * (16 * NW + NG);
    localparam int T_LAST_RISE = CD + 2 * CD * (16 * NW - 1);

    logic        i_clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic        i_clr_ovr;
    logic        i_sd;
    logic        o_sclk;
    logic        o_fs;
    logic        o_busy;
    logic        o_ovr;
    logic [15:0] o_frame_cnt;

    rcvr_frame_ctrl_if dn_if ();

    rcvr_frame_ctrl #(
        .CLK_DIV (CD),
        .WORDS   (NW),
        .GAP     (NG)
    ) dut (
        .i_clk       (i_clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_clr_ovr   (i_clr_ovr),
        .o_sclk      (o_sclk),
        .o_fs        (o_fs),
        .i_sd        (i_sd),
        .dn          (dn_if),
        .o_busy      (o_busy),
        .o_ovr       (o_ovr),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] frame_words [NF][NW];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // Reference model state
    bit          m_in_frame = 1'b0;
    int          m_s        = 0;
    int          m_frame    = -1;
    logic        e_vld;
    logic        e_sof;
    logic        e_ovr;
    logic [15:0] e_data;
    logic [15:0] e_fcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Index of the word handed downstream at frame offset t, or -1.
    function automatic int deliver_word(input int t);
        int x;
        x = t - CD - 1;
        if (x < 0 || (x % (2 * CD)) != 0) return -1;
        x = x / (2 * CD);
        if ((x % 16) != 15) return -1;
        if ((x / 16) >= NW) return -1;
        return x / 16;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        e_vld  = 1'b0;
        e_sof  = 1'b0;
        e_ovr  = 1'b0;
        e_data = '0;
        e_fcnt = '0;
    endtask

    task automatic model_edge(input logic en, input logic rdy, input logic clr);
        int   t;
        int   w;
        logic ovr_evt;
        if (m_in_frame && (cyc - m_s) == PERIOD) begin
            if (en) begin
                m_s = cyc;
                m_frame++;
            end else begin
                m_in_frame = 1'b0;
            end
        end else if (!m_in_frame && en) begin
            m_in_frame = 1'b1;
            m_s = cyc;
            m_frame++;
        end
        t = cyc - m_s;
        w = m_in_frame ? deliver_word(t) : -1;
        ovr_evt = (w >= 0) && e_vld && !rdy;
        if (w >= 0 && (!e_vld || rdy)) begin
            e_vld  = 1'b1;
            e_data = frame_words[m_frame % NF][w];
            e_sof  = (w == 0);
        end else if (e_vld && rdy) begin
            e_vld = 1'b0;
        end
        if (ovr_evt) e_ovr = 1'b1;
        else if (clr) e_ovr = 1'b0;
        if (m_in_frame && t == T_LAST_RISE) e_fcnt = e_fcnt + 16'd1;
    endtask

    task automatic check_all();
        int   t;
        logic es;
        logic efs;
        logic eb;
        if (m_in_frame) begin
            t   = cyc - m_s;
            es  = ((t / CD) % 2) == 1;
            efs = (t < 2 * CD);
            eb  = 1'b1;
        end else begin
            es  = 1'b1;
            efs = 1'b0;
            eb  = 1'b0;
        end
        chk("sclk", 32'(o_sclk), 32'(es));
        chk("fs", 32'(o_fs), 32'(efs));
        chk("busy", 32'(o_busy), 32'(eb));
        chk("vld", 32'(dn_if.o_vld), 32'(e_vld));
        chk("ovr", 32'(o_ovr), 32'(e_ovr));
        chk("frame_cnt", 32'(o_frame_cnt), 32'(e_fcnt));
        if (e_vld) begin
            chk("data", 32'(dn_if.o_data), 32'(e_data));
            chk("sof", 32'(dn_if.o_sof), 32'(e_sof));
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        cyc++;
        if (!rst) model_edge(i_en, dn_if.i_rdy, i_clr_ovr);
        #1;
        check_all();
    endtask

    task automatic reset_now();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_data", 32'(dn_if.o_data), 32'h0);
        chk("rst_sof", 32'(dn_if.o_sof), 32'h0);
        repeat (2) step();
        @(negedge i_clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2 * PERIOD && m_in_frame; k++) step();
    endtask

    // Far end: presents the next bit on every falling sclk; fs marks bit 0 of a frame.
    initial begin : far_end
        int          drv_frame;
        int          drv_bit;
        logic [15:0] w;
        drv_frame = -1;
        drv_bit   = 0;
        i_sd      = 1'b0;
        forever begin
            @(negedge o_sclk);
            #1;
            if (o_fs) begin
                drv_frame++;
                drv_bit = 0;
            end else begin
                drv_bit++;
            end
            if (drv_frame >= 0 && drv_bit < 16 * NW) begin
                w    = frame_words[drv_frame % NF][drv_bit / 16];
                i_sd = w[15 - (drv_bit % 16)];
            end else begin
                i_sd = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : main
        int lat;
        int td1;
        int rdy_pct;
        for (int f = 0; f < NF; f++)
            for (int w = 0; w < NW; w++)
                frame_words[f][w] = 16'($urandom);
        frame_words[0][0] = 16'hA5C3;
        frame_words[0][1] = 16'h1234;

        i_en         = 1'b0;
        i_clr_ovr    = 1'b0;
        dn_if.i_rdy  = 1'b1;
        reset_now();

        // First frame: latency to the first word, then continuous frames.
        i_en = 1'b1;
        lat  = -1;
        begin : lat_wait
            int n0;
            n0 = cyc;
            for (int k = 0; k < 200 && lat < 0; k++) begin
                step();
                if (dn_if.o_vld === 1'b1) lat = cyc - n0;
            end
        end
        chk("first_vld_latency", 32'(lat), 32'(1 + CD + 15 * 2 * CD + 1));
        repeat (2 * PERIOD) step();
        i_en = 1'b0;
        wait_idle();

        // Consumer stalled for a whole frame, i_en dropped after the first rise.
        dn_if.i_rdy = 1'b0;
        i_en = 1'b1;
        step();
        repeat (CD + 1) step();
        i_en = 1'b0;
        wait_idle();
        chk("ovr_after_stall", 32'(o_ovr), 32'h1);
        chk("held_word0", 32'(dn_if.o_data), 32'(frame_words[m_frame % NF][0]));
        i_clr_ovr = 1'b1;
        step();
        i_clr_ovr = 1'b0;
        step();
        dn_if.i_rdy = 1'b1;
        step();
        dn_if.i_rdy = 1'b0;

        // Accept lands on the same cycle word 1 is delivered.
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        td1 = CD + 2 * CD * (16 + 15) + 1;
        while (cyc + 1 < m_s + td1) step();
        dn_if.i_rdy = 1'b1;
        step();
        chk("same_cycle_word1", 32'(dn_if.o_data), 32'(frame_words[m_frame % NF][1]));
        dn_if.i_rdy = 1'b0;
        wait_idle();
        dn_if.i_rdy = 1'b1;
        step();

        // Randomised traffic.
        i_en    = 1'b1;
        rdy_pct = 90;
        for (int k = 0; k < 1500; k++) begin
            if ((k % 100) == 0) rdy_pct = ($urandom_range(0, 1) == 0) ? 90 : 3;
            dn_if.i_rdy = ($urandom_range(0, 99) < rdy_pct);
            i_clr_ovr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) i_en = ~i_en;
            step();
        end
        i_clr_ovr   = 1'b0;
        dn_if.i_rdy = 1'b1;
        i_en        = 1'b0;
        wait_idle();

        // Reset in the middle of a word, then a clean frame with i_en held high.
        i_en = 1'b1;
        repeat (40) step();
        #2;
        reset_now();
        repeat (2 * PERIOD) step();
        i_en = 1'b0;
        wait_idle();
        chk("end_sclk_idle", 32'(o_sclk), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
